// File: rtl/cvp14_mem.sv
// Word-addressed memory responder for the CVP14 bus. It adds a side-band preload port,
// a sticky error flag and saturating read/write access counters.
//
// state   | meaning
// IDLE    | no access on the last edge
// RRESP   | read completed on the last edge, DataIn valid
// WACK    | write completed on the last edge
// ERR_CYC | RD and WR were both high on the last edge
module cvp14_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataOut,
    output logic [15:0] DataIn,
    output logic        Ack,
    output logic        Err,
    input  logic        LdEn,
    input  logic [15:0] LdAddr,
    input  logic [15:0] LdData,
    output logic [15:0] RdCnt,
    output logic [15:0] WrCnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RRESP   = 2'd1,
        WACK    = 2'd2,
        ERR_CYC = 2'd3
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic [15:0] mem [DEPTH];

    state_t      state, state_nxt;
    logic [15:0] data_q, data_nxt;
    logic        err_q, err_nxt;
    logic [15:0] rd_cnt, rd_cnt_nxt;
    logic [15:0] wr_cnt, wr_cnt_nxt;

    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [15:0]   mem_wdata;

    logic          addr_ok, ld_ok;
    logic [AW-1:0] addr_idx, ld_idx;

    // The range check uses the full 16 bits, and only then is the index truncated.
    assign addr_ok  = ({1'b0, Addr} < DEPTH_W);
    assign ld_ok    = ({1'b0, LdAddr} < DEPTH_W);
    assign addr_idx = Addr[AW-1:0];
    assign ld_idx   = LdAddr[AW-1:0];

    always_comb begin
        state_nxt  = IDLE;
        data_nxt   = data_q;
        err_nxt    = err_q;
        rd_cnt_nxt = rd_cnt;
        wr_cnt_nxt = wr_cnt;
        mem_we     = 1'b0;
        mem_idx    = addr_idx;
        mem_wdata  = DataOut;

        unique case ({RD, WR})
            2'b11: begin
                state_nxt = ERR_CYC;
                err_nxt   = 1'b1;
            end
            2'b10: begin
                state_nxt  = RRESP;
                rd_cnt_nxt = (rd_cnt == 16'hFFFF) ? rd_cnt : rd_cnt + 16'd1;
                if (addr_ok) begin
                    data_nxt = mem[addr_idx];
                end else begin
                    data_nxt = 16'h0000;
                    err_nxt  = 1'b1;
                end
            end
            2'b01: begin
                state_nxt = WACK;
                if (addr_ok) begin
                    mem_we     = 1'b1;
                    wr_cnt_nxt = (wr_cnt == 16'hFFFF) ? wr_cnt : wr_cnt + 16'd1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                if (LdEn) begin
                    if (ld_ok) begin
                        mem_we     = 1'b1;
                        mem_idx    = ld_idx;
                        mem_wdata  = LdData;
                        wr_cnt_nxt = (wr_cnt == 16'hFFFF) ? wr_cnt : wr_cnt + 16'd1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        endcase

        // A preload that collides with a bus request is dropped and flagged.
        if (LdEn && (RD || WR)) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state  <= IDLE;
            data_q <= 16'h0000;
            err_q  <= 1'b0;
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            err_q  <= err_nxt;
            rd_cnt <= rd_cnt_nxt;
            wr_cnt <= wr_cnt_nxt;
        end
    end

    // The array has no reset, so its contents survive Reset. Reset still blocks the write on its edge.
    always_ff @(posedge Clk1) begin
        if (!Reset && mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    assign DataIn = data_q;
    assign Ack    = (state == RRESP) || (state == WACK);
    assign Err    = err_q;
    assign RdCnt  = rd_cnt;
    assign WrCnt  = wr_cnt;

endmodule

// File: tb/tb_cvp14_mem.sv
// Self-checking bench for cvp14_mem. It applies table-driven vectors and hand-written
// streaming and saturation sequences, and checks results through an expected-value queue.
module tb_cvp14_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] dout;
    logic [15:0] din;
    logic        ack;
    logic        err;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cvp14_mem #(.DEPTH(1024), .AW(10)) dut (
        .Clk1    (clk),
        .Reset   (rst),
        .Addr    (addr),
        .RD      (rd),
        .WR      (wr),
        .DataOut (dout),
        .DataIn  (din),
        .Ack     (ack),
        .Err     (err),
        .LdEn    (ld_en),
        .LdAddr  (ld_addr),
        .LdData  (ld_data),
        .RdCnt   (rd_cnt),
        .WrCnt   (wr_cnt)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dout;
        logic        ld;
        logic [15:0] ldaddr;
        logic [15:0] lddata;
        logic [15:0] e_din;
        logic        e_ack;
        logic        e_err;
        logic [15:0] e_rc;
        logic [15:0] e_wc;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] din;
        logic        ack;
        logic        err;
        logic [15:0] rc;
        logic [15:0] wc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[22];

    function automatic vec_t mk(string n, logic r, logic rdv, logic wrv, logic [15:0] a,
                                logic [15:0] d, logic l, logic [15:0] la, logic [15:0] ldv,
                                logic [15:0] edin, logic eack, logic eerr,
                                logic [15:0] erc, logic [15:0] ewc);
        vec_t v;
        v.name = n; v.rst = r; v.rd = rdv; v.wr = wrv; v.addr = a; v.dout = d;
        v.ld = l; v.ldaddr = la; v.lddata = ldv;
        v.e_din = edin; v.e_ack = eack; v.e_err = eerr; v.e_rc = erc; v.e_wc = ewc;
        return v;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    // Drive one cycle at the falling edge, then compare against the queued expectation after the rising edge.
    task automatic step(input vec_t v, input bit check);
        exp_t e;
        @(negedge clk);
        rst = v.rst; rd = v.rd; wr = v.wr; addr = v.addr; dout = v.dout;
        ld_en = v.ld; ld_addr = v.ldaddr; ld_data = v.lddata;
        if (check) begin
            e.name = v.name; e.din = v.e_din; e.ack = v.e_ack; e.err = v.e_err;
            e.rc = v.e_rc; e.wc = v.e_wc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (check) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s scoreboard_empty actual=0 expected=1", v.name);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".DataIn"}, din, e.din);
                chk({e.name, ".Ack"}, {15'd0, ack}, {15'd0, e.ack});
                chk({e.name, ".Err"}, {15'd0, err}, {15'd0, e.err});
                chk({e.name, ".RdCnt"}, rd_cnt, e.rc);
                chk({e.name, ".WrCnt"}, wr_cnt, e.wc);
            end
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; dout = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        //             name            rst rd wr addr      dout      ld ldaddr    lddata    din       ack err rc     wc
        tbl[0]  = mk("reset",          1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0);
        tbl[1]  = mk("preload5",       0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0005, 16'h7A3C, 16'h0000, 0, 0, 16'd0, 16'd1);
        tbl[2]  = mk("read5",          0, 1, 0, 16'h0005, 16'h0000, 0, 16'h0000, 16'h0000, 16'h7A3C, 1, 0, 16'd1, 16'd1);
        tbl[3]  = mk("idle_hold",      0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h7A3C, 0, 0, 16'd1, 16'd1);
        tbl[4]  = mk("write10",        0, 0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 16'h0000, 16'h7A3C, 1, 0, 16'd1, 16'd2);
        tbl[5]  = mk("read10",         0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 16'd2, 16'd2);
        tbl[6]  = mk("idle2",          0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 16'd2, 16'd2);
        tbl[7]  = mk("preload2",       0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 16'h1111, 16'hBEEF, 0, 0, 16'd2, 16'd3);
        tbl[8]  = mk("rdwr_both",      0, 1, 1, 16'h0002, 16'h2222, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 1, 16'd2, 16'd3);
        tbl[9]  = mk("read2_unchg",    0, 1, 0, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1111, 1, 1, 16'd3, 16'd3);
        tbl[10] = mk("read_oor",       0, 1, 0, 16'h0400, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'd4, 16'd3);
        tbl[11] = mk("write_oor",      0, 0, 1, 16'h0400, 16'h1234, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'd4, 16'd3);
        tbl[12] = mk("preload_oor",    0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0400, 16'h4321, 16'h0000, 0, 1, 16'd4, 16'd3);
        tbl[13] = mk("write3ff",       0, 0, 1, 16'h03FF, 16'h5A5A, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'd4, 16'd4);
        tbl[14] = mk("read3ff",        0, 1, 0, 16'h03FF, 16'h0000, 0, 16'h0000, 16'h0000, 16'h5A5A, 1, 1, 16'd5, 16'd4);
        tbl[15] = mk("reset2",         1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0);
        tbl[16] = mk("wr_ld_conflict", 0, 0, 1, 16'h0020, 16'hCAFE, 1, 16'h0020, 16'hDEAD, 16'h0000, 1, 1, 16'd0, 16'd1);
        tbl[17] = mk("read20",         0, 1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 16'h0000, 16'hCAFE, 1, 1, 16'd1, 16'd1);
        tbl[18] = mk("reset_mid_wr",   1, 0, 1, 16'h0020, 16'h0BAD, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 16'd0);
        tbl[19] = mk("read20_kept",    0, 1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 16'h0000, 16'hCAFE, 1, 0, 16'd1, 16'd0);
        tbl[20] = mk("read5_kept",     0, 1, 0, 16'h0005, 16'h0000, 0, 16'h0000, 16'h0000, 16'h7A3C, 1, 0, 16'd2, 16'd0);
        tbl[21] = mk("idle3",          0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h7A3C, 0, 0, 16'd2, 16'd0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i], 1'b1);
        end

        // Streaming read: preload mem[i] = i*3, then hold RD high while Addr walks 0..15.
        step(mk("s_reset", 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 16'd0, 16'd0), 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = mk("s_preload", 0, 0, 0, 16'h0, 16'h0, 1, 16'(i), 16'(i * 3),
                   16'h0, 0, 0, 16'd0, 16'(i + 1));
            step(v, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            v = mk("s_read", 0, 1, 0, 16'(i), 16'h0, 0, 16'h0, 16'h0,
                   16'(i * 3), 1, 0, 16'(i + 1), 16'd16);
            step(v, 1'b1);
        end
        step(mk("s_end", 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'd45, 0, 0, 16'd16, 16'd16), 1'b1);

        // Saturation: bring RdCnt to 16'hFFFE with unchecked reads, then do three checked reads.
        step(mk("sat_reset", 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 16'd0, 16'd0), 1'b1);
        v = mk("sat_fill", 0, 1, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 32'hFFFE; i++) begin
            step(v, 1'b0);
        end
        chk("sat_pre.RdCnt", rd_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(mk("sat_read", 0, 1, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 1, 0, 16'hFFFF, 16'h0), 1'b1);
        end
        step(mk("sat_idle", 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 16'hFFFF, 16'h0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
